// File: rtl/ibert_chan_seq_if.sv
// Configuration handshake bundle between IBERT top-level control (master)
// and the per-channel sequencer (slave).
interface ibert_chan_seq_if #(
  parameter int unsigned CLKW = 25
);
  logic            cfg_valid;
  logic            cfg_ready;
  logic [2:0]      cfg_width;
  logic [CLKW-1:0] cfg_wanted_clk;
  logic [CLKW-1:0] cfg_sys_clk;
  logic [31:0]     run_len;
  logic            stop_req;

  modport master (
    output cfg_valid,
    output cfg_width,
    output cfg_wanted_clk,
    output cfg_sys_clk,
    output run_len,
    output stop_req,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_width,
    input  cfg_wanted_clk,
    input  cfg_sys_clk,
    input  run_len,
    input  stop_req,
    output cfg_ready
  );
endinterface

// File: rtl/ibert_chan_seq.sv
// Per-channel sequencer: accepts a channel configuration, then drives the
// wrapper through reset -> settle -> run and reports run status.
module ibert_chan_seq #(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CLKW          = 25
) (
  input  logic            clock,
  input  logic            reset_n,
  ibert_chan_seq_if.slave cfg,
  output logic [2:0]      ctrl_sig,
  output logic [2:0]      val,
  output logic [CLKW-1:0] wanted_cl_val,
  output logic [CLKW-1:0] earlier_cl_val,
  output logic            chan_active,
  output logic            busy,
  output logic            done,
  output logic            cfg_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RESET  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  localparam logic [2:0] CTRL_HOLD    = 3'd0;
  localparam logic [2:0] CTRL_RESET   = 3'd1;
  localparam logic [2:0] CTRL_RELEASE = 3'd2;

  localparam logic [15:0] RST_LOAD    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

  logic [1:0]      state_q,   state_d;
  logic [15:0]     cnt_q,     cnt_d;
  logic [31:0]     run_cnt_q, run_cnt_d;
  logic [31:0]     run_len_q, run_len_d;
  logic [2:0]      val_q,     val_d;
  logic [CLKW-1:0] wanted_q,  wanted_d;
  logic [CLKW-1:0] earlier_q, earlier_d;
  logic            done_q,    done_d;
  logic            cfg_err_q, cfg_err_d;

  logic hs;
  logic cfg_legal;
  logic run_expire;

  always_comb begin
    cfg.cfg_ready = reset_n && ((state_q == S_IDLE) || (state_q == S_RUN));
  end

  always_comb begin
    hs        = cfg.cfg_valid && cfg.cfg_ready;
    cfg_legal = (cfg.cfg_width <= 3'd4) &&
                (cfg.cfg_wanted_clk != '0) &&
                (cfg.cfg_wanted_clk <= cfg.cfg_sys_clk);
    // run_cnt_q holds completed active cycles, so the current one is the last
    // when it equals run_len-1; this never needs the counter to wrap.
    run_expire = (run_len_q != '0) && (run_cnt_q == run_len_q - 32'd1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_cnt_d = run_cnt_q;
    run_len_d = run_len_q;
    val_d     = val_q;
    wanted_d  = wanted_q;
    earlier_d = earlier_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;

    case (state_q)
      S_RESET: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d   = S_RUN;
          run_cnt_d = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RUN: begin
        if (run_len_q != '0) begin
          run_cnt_d = run_cnt_q + 32'd1;
        end
        if (run_expire) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase

    // stop_req outranks any handshake; a legal handshake outranks run expiry,
    // and a RUN left either way yields exactly one done pulse.
    if (cfg.stop_req && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = (state_q == S_RUN);
    end else if (hs && !cfg.stop_req) begin
      if (cfg_legal) begin
        state_d   = S_RESET;
        cnt_d     = RST_LOAD;
        run_cnt_d = '0;
        run_len_d = cfg.run_len;
        val_d     = cfg.cfg_width;
        wanted_d  = cfg.cfg_wanted_clk;
        earlier_d = cfg.cfg_sys_clk;
        done_d    = (state_q == S_RUN);
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      run_cnt_q <= '0;
      run_len_q <= '0;
      val_q     <= '0;
      wanted_q  <= '0;
      earlier_q <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_cnt_q <= run_cnt_d;
      run_len_q <= run_len_d;
      val_q     <= val_d;
      wanted_q  <= wanted_d;
      earlier_q <= earlier_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    case (state_q)
      S_RESET:  ctrl_sig = CTRL_RESET;
      S_SETTLE: ctrl_sig = CTRL_RELEASE;
      S_RUN:    ctrl_sig = CTRL_RELEASE;
      default:  ctrl_sig = CTRL_HOLD;
    endcase
    chan_active    = (state_q == S_RUN);
    busy           = (state_q != S_IDLE);
    val            = val_q;
    wanted_cl_val  = wanted_q;
    earlier_cl_val = earlier_q;
    done           = done_q;
    cfg_err        = cfg_err_q;
  end

endmodule
